// File: rtl/custom_axi_regif.sv
// APB register interface toward the custom IP: three write words with
// per-word update strobe / acknowledge handshake, and three captured read fields.
module custom_axi_regif #(
    parameter int unsigned DATA_WIDTH  = 96,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [11:0]           paddr_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [31:0]           pwdata_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [DATA_WIDTH-1:0] reg2ip_data_o,
    output logic [2:0]            reg2ip_en_o,
    input  logic [2:0]            reg2ip_ack_i,
    input  logic [DATA_WIDTH+2:0] ip2reg_data_i,
    input  logic [2:0]            ip2reg_en_i
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned FIELD_W = WORD_W + 1;
    localparam int unsigned F0_HI   = DATA_WIDTH + 2;
    localparam int unsigned F1_HI   = F0_HI - FIELD_W;
    localparam int unsigned F2_HI   = F1_HI - FIELD_W;
    localparam int unsigned CNT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT, DONE} state_e;

    state_e                   state_q, state_d;
    logic [2:0][WORD_W-1:0]   w_q, w_d;
    logic [2:0][WORD_W-1:0]   r_q, r_d;
    logic [2:0]               flag_q, flag_d;
    logic [2:0]               valid_q, valid_d;
    logic [2:0]               tout_q, tout_d;
    logic [1:0]               sel_q, sel_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [31:0]              prdata_d;
    logic                     pready_d, pslverr_d;
    logic [2:0]               en_d;
    logic [2:0]               clr_c;

    logic [9:0]               widx_c;
    logic                     access_c, is_w_c, is_r_c, is_st_c;
    logic [1:0]               ridx_c;
    logic [31:0]              rdata_c;
    logic                     unused_paddr_c;

    // Word-address decode of the APB access
    assign widx_c         = paddr_i[11:2];
    assign access_c       = psel_i & penable_i;
    assign is_w_c         = (widx_c <= 10'd2);
    assign is_r_c         = (widx_c >= 10'd3) && (widx_c <= 10'd5);
    assign is_st_c        = (widx_c == 10'd6);
    assign ridx_c         = 2'(widx_c - 10'd3);
    assign unused_paddr_c = ^paddr_i[1:0];

    assign reg2ip_data_o  = DATA_WIDTH'({w_q[0], w_q[1], w_q[2]});

    // Read mux over current register state (before any same-edge capture)
    always_comb begin
        rdata_c = '0;
        if (is_w_c) begin
            rdata_c = w_q[widx_c[1:0]];
        end else if (is_r_c) begin
            rdata_c = r_q[ridx_c];
        end else if (is_st_c) begin
            rdata_c = {23'd0, tout_q, valid_q, flag_q};
        end
    end

    // Transfer FSM: next state, write words, timeout tracking and registered outputs
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        tout_d    = tout_q;
        clr_c     = '0;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        en_d      = '0;
        unique case (state_q)
            IDLE: begin
                if (access_c) begin
                    if (pwrite_i && is_w_c) begin
                        w_d[widx_c[1:0]] = pwdata_i;
                        sel_d            = widx_c[1:0];
                        cnt_d            = '0;
                        en_d             = 3'b001 << widx_c[1:0];
                        state_d          = PULSE;
                    end else begin
                        state_d  = DONE;
                        pready_d = 1'b1;
                        if (pwrite_i) begin
                            pslverr_d = !is_st_c;
                            if (is_st_c) begin
                                tout_d = tout_q & ~pwdata_i[8:6];
                            end
                        end else begin
                            pslverr_d = !(is_w_c || is_r_c || is_st_c);
                            prdata_d  = rdata_c;
                            if (is_r_c) begin
                                clr_c[ridx_c] = 1'b1;
                            end
                        end
                    end
                end
            end
            PULSE, WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (reg2ip_ack_i[sel_q]) begin
                    state_d  = DONE;
                    pready_d = 1'b1;
                end else if ((state_q == WAIT) && (cnt_q == CNT_LAST)) begin
                    state_d       = DONE;
                    pready_d      = 1'b1;
                    pslverr_d     = 1'b1;
                    tout_d[sel_q] = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // IP-side capture; a capture wins over a same-cycle read-clear of valid
    always_comb begin
        r_d    = r_q;
        flag_d = flag_q;
        if (ip2reg_en_i[0]) begin
            r_d[0]    = ip2reg_data_i[F0_HI -: WORD_W];
            flag_d[0] = ip2reg_data_i[F0_HI - WORD_W];
        end
        if (ip2reg_en_i[1]) begin
            r_d[1]    = ip2reg_data_i[F1_HI -: WORD_W];
            flag_d[1] = ip2reg_data_i[F1_HI - WORD_W];
        end
        if (ip2reg_en_i[2]) begin
            r_d[2]    = ip2reg_data_i[F2_HI -: WORD_W];
            flag_d[2] = ip2reg_data_i[F2_HI - WORD_W];
        end
        valid_d = (valid_q & ~clr_c) | ip2reg_en_i;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            w_q         <= '0;
            r_q         <= '0;
            flag_q      <= '0;
            valid_q     <= '0;
            tout_q      <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            prdata_o    <= '0;
            pready_o    <= 1'b0;
            pslverr_o   <= 1'b0;
            reg2ip_en_o <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            r_q         <= r_d;
            flag_q      <= flag_d;
            valid_q     <= valid_d;
            tout_q      <= tout_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            prdata_o    <= prdata_d;
            pready_o    <= pready_d;
            pslverr_o   <= pslverr_d;
            reg2ip_en_o <= en_d;
        end
    end

endmodule

// File: tb/tb_custom_axi_regif.sv
// Scoreboard bench for custom_axi_regif: APB driver + IP ack model push
// expectations; monitors pop and compare on pready_o and reg2ip_en_o.
module tb_custom_axi_regif;

    localparam int AT = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [11:0] paddr_i;
    logic        psel_i, penable_i, pwrite_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic [95:0] reg2ip_data_o;
    logic [2:0]  reg2ip_en_o;
    logic [2:0]  reg2ip_ack_i;
    logic [98:0] ip2reg_data_i;
    logic [2:0]  ip2reg_en_i;

    custom_axi_regif #(.DATA_WIDTH(96), .ACK_TIMEOUT(AT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .paddr_i(paddr_i), .psel_i(psel_i),
        .penable_i(penable_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .reg2ip_data_o(reg2ip_data_o), .reg2ip_en_o(reg2ip_en_o),
        .reg2ip_ack_i(reg2ip_ack_i), .ip2reg_data_i(ip2reg_data_i),
        .ip2reg_en_i(ip2reg_en_i)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { logic [31:0] prdata; logic err; int lat; int start; } rsp_t;
    typedef struct { logic [2:0] en; int cyc; logic [95:0] data; } stb_t;
    rsp_t rsp_q[$];
    stb_t stb_q[$];
    rsp_t mon_r;
    stb_t mon_s;

    // Reference model of the register map
    logic [31:0] m_w[3];
    logic [31:0] m_r[3];
    logic [2:0]  m_flag, m_valid, m_tout;

    int ack_delay = -1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_w[k] = '0;
            m_r[k] = '0;
        end
        m_flag = '0; m_valid = '0; m_tout = '0;
    endtask

    function automatic logic [98:0] pack(input logic [2:0][31:0] d, input logic [2:0] f);
        return {d[0], f[0], d[1], f[1], d[2], f[2]};
    endfunction

    task automatic model_capture(input logic [2:0] en, input logic [2:0][31:0] d, input logic [2:0] f);
        for (int k = 0; k < 3; k++) begin
            if (en[k]) begin
                m_r[k] = d[k];
                m_flag[k] = f[k];
                m_valid[k] = 1'b1;
            end
        end
    endtask

    // Response monitor
    always @(negedge clk_i) begin
        if (pready_o === 1'b1) begin
            if (rsp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pready at cycle %0d", cyc);
            end else begin
                mon_r = rsp_q.pop_front();
                chk("prdata", 96'(prdata_o), 96'(mon_r.prdata));
                chk("pslverr", 96'(pslverr_o), 96'(mon_r.err));
                chk("latency", 96'(cyc - mon_r.start), 96'(mon_r.lat));
            end
        end
    end

    // Update-strobe monitor
    always @(negedge clk_i) begin
        if ((|reg2ip_en_o) === 1'b1) begin
            if (stb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_strobe at cycle %0d: got %0b", cyc, reg2ip_en_o);
            end else begin
                mon_s = stb_q.pop_front();
                chk("strobe_en", 96'(reg2ip_en_o), 96'(mon_s.en));
                chk("strobe_cycle", 96'(cyc), 96'(mon_s.cyc));
                chk("reg2ip_data", reg2ip_data_o, mon_s.data);
            end
        end
    end

    // IP acknowledge model with noise on the non-selected ack bits
    logic       ack_pending = 1'b0;
    logic       ack_active = 1'b0;
    int         ack_cnt = 0;
    int         ack_k = 0;
    logic [2:0] ack_v;
    always @(negedge clk_i) begin
        if (rst_i === 1'b1 || pready_o === 1'b1) begin
            ack_pending = 1'b0;
            ack_active  = 1'b0;
        end
        if ((|reg2ip_en_o) === 1'b1) begin
            ack_k       = reg2ip_en_o[0] ? 0 : (reg2ip_en_o[1] ? 1 : 2);
            ack_active  = 1'b1;
            ack_pending = (ack_delay >= 0);
            ack_cnt     = ack_delay;
        end
        ack_v = ack_active ? (3'($urandom) & ~(3'b001 << ack_k)) : 3'b000;
        if (ack_pending) begin
            if (ack_cnt == 0) begin
                ack_v[ack_k] = 1'b1;
                ack_pending  = 1'b0;
            end else begin
                ack_cnt--;
            end
        end
        reg2ip_ack_i = ack_v;
    end

    // One APB transfer; optional capture driven in the access-phase cycle
    task automatic apb(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                       input int ackd, input logic [2:0] cap_en,
                       input logic [2:0][31:0] cap_d, input logic [2:0] cap_f);
        int idx, a, n;
        rsp_t r;
        stb_t s;
        @(negedge clk_i);
        paddr_i = addr; pwrite_i = wr; pwdata_i = wd;
        psel_i = 1'b1; penable_i = 1'b0; ack_delay = ackd;
        @(negedge clk_i);
        penable_i = 1'b1;
        a = cyc;
        idx = int'(addr[11:2]);
        r.prdata = '0; r.err = 1'b0; r.lat = 1; r.start = a;
        if (wr) begin
            if (idx <= 2) begin
                m_w[idx] = wd;
                if (ackd < 0 || ackd >= AT) begin
                    r.err = 1'b1; r.lat = AT + 1; m_tout[idx] = 1'b1;
                end else begin
                    r.lat = 2 + ackd;
                end
                s.en = 3'b001 << idx; s.cyc = a + 1; s.data = {m_w[0], m_w[1], m_w[2]};
                stb_q.push_back(s);
            end else if (idx == 6) begin
                m_tout = m_tout & ~wd[8:6];
            end else begin
                r.err = 1'b1;
            end
        end else begin
            if (idx <= 2) r.prdata = m_w[idx];
            else if (idx <= 5) begin
                r.prdata = m_r[idx-3];
                m_valid[idx-3] = 1'b0;
            end else if (idx == 6) r.prdata = {23'd0, m_tout, m_valid, m_flag};
            else r.err = 1'b1;
        end
        rsp_q.push_back(r);
        ip2reg_data_i = pack(cap_d, cap_f);
        ip2reg_en_i = cap_en;
        model_capture(cap_en, cap_d, cap_f);
        n = 0;
        do begin
            @(negedge clk_i);
            ip2reg_en_i = 3'b000;
            n++;
        end while (pready_o !== 1'b1 && n < 40);
        if (pready_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL pready_timeout addr %0h: got no pready within %0d cycles, expected one", addr, n);
            if (rsp_q.size() > 0) void'(rsp_q.pop_back());
        end
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    task automatic rd(input logic [11:0] addr);
        apb(addr, 1'b0, 32'h0, 0, 3'b000, '0, 3'b000);
    endtask

    task automatic capture(input logic [2:0] en, input logic [2:0][31:0] d, input logic [2:0] f);
        @(negedge clk_i);
        ip2reg_data_i = pack(d, f);
        ip2reg_en_i = en;
        model_capture(en, d, f);
        @(negedge clk_i);
        ip2reg_en_i = 3'b000;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_pready"}, 96'(pready_o), 96'(0));
        chk({tag, "_pslverr"}, 96'(pslverr_o), 96'(0));
        chk({tag, "_prdata"}, 96'(prdata_o), 96'(0));
        chk({tag, "_en"}, 96'(reg2ip_en_o), 96'(0));
        chk({tag, "_data"}, reg2ip_data_o, 96'(0));
    endtask

    // Reset asserted while a write is waiting for its acknowledge
    task automatic reset_mid();
        stb_t s;
        @(negedge clk_i);
        paddr_i = 12'h004; pwrite_i = 1'b1; pwdata_i = 32'hA5A5_0F0F;
        psel_i = 1'b1; penable_i = 1'b0; ack_delay = -1;
        @(negedge clk_i);
        penable_i = 1'b1;
        m_w[1] = pwdata_i;
        s.en = 3'b010; s.cyc = cyc + 1; s.data = {m_w[0], m_w[1], m_w[2]};
        stb_q.push_back(s);
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk_i);
        check_outputs_zero("midreset");
        rst_i = 1'b0;
        model_reset();
        repeat (AT + 8) @(negedge clk_i);
    endtask

    initial begin
        int idx, ackd, sel;
        logic [2:0][31:0] cd;
        rst_i = 1'b1; paddr_i = '0; psel_i = 1'b0; penable_i = 1'b0;
        pwrite_i = 1'b0; pwdata_i = '0; ip2reg_data_i = '0; ip2reg_en_i = '0;
        reg2ip_ack_i = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check_outputs_zero("reset");
        rst_i = 1'b0;

        // Write W0 with immediate ack, read it back
        apb(12'h000, 1'b1, 32'h1234_5678, 0, 3'b000, '0, 3'b000);
        rd(12'h000);
        // Delayed ack, then no ack (timeout), status and its clear
        apb(12'h008, 1'b1, 32'hCAFE_0001, 5, 3'b000, '0, 3'b000);
        apb(12'h008, 1'b1, 32'hCAFE_0001, -1, 3'b000, '0, 3'b000);
        rd(12'h018);
        apb(12'h018, 1'b1, 32'h0000_0100, 0, 3'b000, '0, 3'b000);
        rd(12'h018);
        // Ack on the timeout cycle wins; one cycle later is a timeout
        apb(12'h004, 1'b1, 32'h0BAD_F00D, AT - 1, 3'b000, '0, 3'b000);
        apb(12'h004, 1'b1, 32'h0BAD_F00E, AT, 3'b000, '0, 3'b000);
        rd(12'h018);
        apb(12'h018, 1'b1, 32'hFFFF_FFFF, 0, 3'b000, '0, 3'b000);
        // Capture of all three fields, read-clear of valid[0]
        capture(3'b111, {32'h0000_48D0, 32'h0000_369C, 32'h0000_2468}, 3'b101);
        rd(12'h018);
        rd(12'h00C);
        rd(12'h018);
        // Read of R1 coinciding with a new capture of field 1
        apb(12'h010, 1'b0, 32'h0, 0, 3'b010, {32'h0, 32'h0000_BEEF, 32'h0}, 3'b000);
        rd(12'h018);
        rd(12'h010);
        rd(12'h018);
        // Unmapped address and write to a read-only register
        rd(12'h01C);
        apb(12'h01C, 1'b1, 32'hDEAD_BEEF, 0, 3'b000, '0, 3'b000);
        apb(12'h00C, 1'b1, 32'hDEAD_BEEF, 0, 3'b000, '0, 3'b000);
        rd(12'h00C);
        rd(12'h018);
        // Reset in the middle of a waiting write
        reset_mid();
        rd(12'h004);
        rd(12'h018);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            idx = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 8);
            sel = $urandom_range(0, 9);
            if (sel == 0) ackd = -1;
            else if (sel == 1) ackd = AT - 1;
            else if (sel == 2) ackd = AT;
            else ackd = $urandom_range(0, 5);
            cd = {$urandom, $urandom, $urandom};
            apb({10'(idx), 2'($urandom)}, 1'($urandom), $urandom, ackd,
                ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000, cd, 3'($urandom));
        end

        repeat (5) @(negedge clk_i);
        chk("rsp_queue_drained", 96'(rsp_q.size()), 96'(0));
        chk("stb_queue_drained", 96'(stb_q.size()), 96'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/custom_axi_regif.md
# custom_axi_regif

Bus-side register interface that drives the reg2ip/ip2reg port of the custom IP. It decodes APB accesses from the SoC peripheral interconnect into three 32-bit write words, pulses a per-word enable toward the IP and waits for its per-word acknowledge (with timeout). It captures the IP's three 33-bit read fields into readable shadow registers.

## Interface
- DATA_WIDTH, 96: width of the reg2ip data bus; three 32-bit words, fixed at 96.
- ACK_TIMEOUT, 16: cycles waited for an IP acknowledge before erroring; must be at least 2.
- clk_i  in  1  the single clock; all logic on its rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- paddr_i  in  12  APB byte address; bits [1:0] ignored.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable; marks the access phase.
- pwrite_i  in  1  1 = write, 0 = read.
- pwdata_i  in  32  APB write data.
- prdata_o  out  32  APB read data; valid while pready_o=1.
- pready_o  out  1  transfer complete; a one-cycle pulse.
- pslverr_o  out  1  error response; valid while pready_o=1.
- reg2ip_data_o  out  DATA_WIDTH  shadow words: {W0, W1, W2}, with W0 in [95:64] and W2 in [31:0].
- reg2ip_en_o  out  3  one-cycle update strobe per word; bit k is for Wk.
- reg2ip_ack_i  in  3  IP acknowledge per word; bit k is for Wk.
- ip2reg_data_i  in  DATA_WIDTH+3  three 33-bit fields {D0,f0,D1,f1,D2,f2}: D0=[98:67], f0=[66], D1=[65:34], f1=[33], D2=[32:1], f2=[0].
- ip2reg_en_i  in  3  capture strobe per field; bit k is for field k.

## Operation
- Register map:
  - 0x00, 0x04, 0x08: W0, W1, W2, read/write.
  - 0x0C, 0x10, 0x14: R0, R1, R2 = captured D0, D1, D2, read-only. Reading Rk clears valid[k].
  - 0x18: STATUS.
    - [2:0] = captured flags {f2,f1,f0}.
    - [5:3] = valid[2:0].
    - [8:6] = sticky timeout[2:0].
    - [31:9] = 0.
    - Writing STATUS with pwdata bit (6+k) set clears timeout[k]; all other STATUS bits ignore writes.
- Any other address: no side effects; completes with pslverr_o=1 and prdata_o=0. Writes to R0..R2 are also errors with no side effects.
- FSM states: IDLE, PULSE, WAIT, DONE.
  - IDLE, access phase (psel_i & penable_i):
    - Write to Wk: latch pwdata_i into Wk, record k, go to PULSE.
    - Every other access: register prdata_o and the error flag, go to DONE.
  - PULSE: reg2ip_en_o[k]=1 for exactly this cycle; clear the timeout counter.
    - reg2ip_ack_i[k]=1: go to DONE, error=0.
    - Otherwise: go to WAIT.
  - WAIT: counter increments each cycle.
    - reg2ip_ack_i[k]=1: go to DONE, error=0.
    - Else, counter == ACK_TIMEOUT-1: go to DONE, error=1, set timeout[k].
    - Ack wins if it arrives in the same cycle as the timeout.
  - DONE: pready_o=1 and pslverr_o=error for one cycle, then IDLE.
- Wk keeps its new value on timeout; no rollback.
- Only the selected ack bit k is monitored; other ack bits are ignored.
- Capture runs independently of the FSM. On ip2reg_en_i[k]=1: Dk goes to Rk, fk goes to flag[k], valid[k] is set.
- Capture and read-clear of the same k in the same cycle:
  - The read returns the old Rk.
  - The new value is stored.
  - valid[k] stays 1.
- Simultaneous captures of several fields are all taken.

## Timing
- Reset values: all registers, outputs, valid and timeout bits are 0; state is IDLE.
  - pready_o=0, pslverr_o=0, prdata_o=0, reg2ip_en_o=0, reg2ip_data_o=0.
- Reset mid-transfer: the state returns to IDLE, no pready_o is issued and no strobe is emitted afterwards. The master must restart the transfer.
- Cycle A is the first access-phase cycle.
- Read and error latency: pready_o is high in cycle A+1.
- Write latency:
  - reg2ip_data_o shows the new word from A+1.
  - reg2ip_en_o[k] is high in A+1.
  - Ack in A+1 gives pready_o in A+2.
  - Ack seen in WAIT cycle A+1+n gives pready_o in A+2+n.
  - With no ack, pready_o with pslverr_o=1 is high in A+1+ACK_TIMEOUT.
- prdata_o is registered on the IDLE->DONE edge. It samples state before any capture on that same edge.
- A new transfer is accepted only from IDLE. The APB setup phase (penable_i=0) guarantees no retrigger after DONE.

## Test plan
- Reset, then write 0x00=0x1234_5678 with ack tied to reg2ip_en_o -> reg2ip_data_o[95:64]=0x12345678; reg2ip_en_o=3'b001 for 1 cycle; pready_o at A+2; pslverr_o=0; readback of 0x00 returns 0x12345678.
- Write 0x08=0xCAFE_0001, ack[2] after 5 cycles -> en=3'b100 once; pready_o at A+7; pslverr_o=0. Repeat with ack never -> pslverr_o=1 at A+17; STATUS[8]=1; writing STATUS=0x100 clears it.
- Drive ip2reg_data_i={0x2468,1,0x369C,0,0x48D0,1} with ip2reg_en_i=3'b111 -> STATUS reads 0x3D, i.e. flags 3'b101 and valid 3'b111. Reading 0x0C returns 0x2468 and clears valid[0], so the next STATUS read is 0x35.
- Read 0x10 in the same cycle as ip2reg_en_i[1] carries a new value 0xBEEF -> the read returns the old value; the next read returns 0xBEEF; valid[1] stays 1 until that read.
- Access 0x1C or write 0x0C -> pready_o at A+1 with pslverr_o=1 and no register change. Assert rst_i during WAIT -> no pready_o and no further reg2ip_en_o; all outputs are 0 next cycle.
